// File: rtl/rs_share_pkg.sv
// -----------------------------------------------------------------------------
// rs_share_pkg
// Shared definitions for the shared-adder scheduler (rs_share_sched).
//   WIDTH_DEF / CNT_W_DEF : default operand width and op-counter width
//   CH0 / CH1             : channel identifiers, also the round-robin pointer values
//   stage_t               : stage-1 record {valid, chan, a, b[, sub]} at the default width
// Optional feature macro: RS_SHARE_SUB_EN (adds the subtract flag to the record).
// -----------------------------------------------------------------------------
package rs_share_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Record layout at the default width. The top re-declares the same layout
    // at its own WIDTH parameter so non-default widths stay consistent.
    typedef struct packed {
        logic                 valid;
        logic                 chan;
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
`ifdef RS_SHARE_SUB_EN
        logic                 sub;
`endif
    } stage_t;

endpackage

// File: rtl/rs_shared_adder.sv
// -----------------------------------------------------------------------------
// rs_shared_adder
// The single combinational adder shared by both channels.
//   i_a, i_b  : operands
//   i_sub     : (RS_SHARE_SUB_EN only) 1 -> a - b as a + ~b + 1
//   o_sum     : WIDTH-bit result (wraps)
//   o_carry   : carry-out; in subtract mode 1 means no borrow (a >= b)
// Optional feature macro: RS_SHARE_SUB_EN.
// -----------------------------------------------------------------------------
module rs_shared_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
`ifdef RS_SHARE_SUB_EN
    input  logic             i_sub,
`endif
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

`ifdef RS_SHARE_SUB_EN
    logic [WIDTH-1:0] w_b_eff;

    // Subtract reuses the same adder: invert b and inject the +1 as carry-in.
    assign w_b_eff            = i_b ^ {WIDTH{i_sub}};
    assign {o_carry, o_sum}   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
`else
    assign {o_carry, o_sum}   = {1'b0, i_a} + {1'b0, i_b};
`endif

endmodule

// File: rtl/rs_share_sched.sv
// -----------------------------------------------------------------------------
// rs_share_sched
// Two requesters share one adder. Round-robin arbiter grants at most one
// channel per cycle; the granted operands go through a 2-stage pipeline
// (operand register -> sum register) and return as a 1-cycle response pulse
// on the granted channel, two cycles after the transfer.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid / reqN_ready         request handshake (ready = granted, combinational)
//   reqN_a, reqN_b [, reqN_sub]     operands (sub only with RS_SHARE_SUB_EN)
//   rspN_valid                      1-cycle result pulse
//   rspN_sum, rspN_carry            result, held between pulses of that channel
//   busy                            an op is in stage 1 or stage 2
//   op_count                        completed ops, saturating
// Optional feature macro: RS_SHARE_SUB_EN (per-channel subtract request).
// -----------------------------------------------------------------------------
module rs_share_sched
    import rs_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
`ifdef RS_SHARE_SUB_EN
    input  logic             req0_sub,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef RS_SHARE_SUB_EN
    input  logic             req1_sub,
`endif
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp0_carry,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp1_carry,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic             valid;
        logic             chan;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
`ifdef RS_SHARE_SUB_EN
        logic             sub;
`endif
    } s1_t;

    logic             w_grant0;
    logic             w_grant1;
    logic             r_rr_ptr;
    s1_t              w_s1_next;
    s1_t              r_s1;
    logic             r_s2_valid;
    logic             r_s2_chan;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] r_rsp0_sum;
    logic             r_rsp0_carry;
    logic [WIDTH-1:0] r_rsp1_sum;
    logic             r_rsp1_carry;
    logic [CNT_W-1:0] r_op_count;

    // Arbiter and stage-1 operand mux.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_grant0  = 1'b0;
        w_grant1  = 1'b0;
        w_s1_next = '0;
        if (req0_valid && req1_valid) begin
            w_grant0 = (r_rr_ptr == CH0);
            w_grant1 = (r_rr_ptr == CH1);
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
        w_s1_next.valid = w_grant0 | w_grant1;
        w_s1_next.chan  = w_grant1 ? CH1 : CH0;
        w_s1_next.a     = w_grant1 ? req1_a : req0_a;
        w_s1_next.b     = w_grant1 ? req1_b : req0_b;
`ifdef RS_SHARE_SUB_EN
        w_s1_next.sub   = w_grant1 ? req1_sub : req0_sub;
`endif
    end

    // NOTE: state is written with <= only, so every flop samples pre-edge values; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= CH0;
            r_s1     <= '0;
        end else begin
            // Point away from whoever just won; hold when nobody was granted.
            if (w_grant0) begin
                r_rr_ptr <= CH1;
            end else if (w_grant1) begin
                r_rr_ptr <= CH0;
            end
            r_s1 <= w_s1_next;
        end
    end

    rs_shared_adder #(
        .WIDTH   (WIDTH)
    ) u_adder (
        .i_a     (r_s1.a),
        .i_b     (r_s1.b),
`ifdef RS_SHARE_SUB_EN
        .i_sub   (r_s1.sub),
`endif
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Stage 2: the sum register is split per channel so each channel's result
    // holds until its own next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_chan    <= CH0;
            r_rsp0_sum   <= '0;
            r_rsp0_carry <= 1'b0;
            r_rsp1_sum   <= '0;
            r_rsp1_carry <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_s2_valid <= r_s1.valid;
            r_s2_chan  <= r_s1.chan;
            if (r_s1.valid && (r_s1.chan == CH0)) begin
                r_rsp0_sum   <= w_sum;
                r_rsp0_carry <= w_carry;
            end
            if (r_s1.valid && (r_s1.chan == CH1)) begin
                r_rsp1_sum   <= w_sum;
                r_rsp1_carry <= w_carry;
            end
            // Count each response pulse; stick at all-ones.
            if (r_s2_valid && (r_op_count != '1)) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp0_valid = r_s2_valid & (r_s2_chan == CH0);
    assign rsp1_valid = r_s2_valid & (r_s2_chan == CH1);
    assign rsp0_sum   = r_rsp0_sum;
    assign rsp0_carry = r_rsp0_carry;
    assign rsp1_sum   = r_rsp1_sum;
    assign rsp1_carry = r_rsp1_carry;
    assign busy       = r_s1.valid | r_s2_valid;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_rs_share_sched.sv
// -----------------------------------------------------------------------------
// tb_rs_share_sched
// Bench for rs_share_sched. Expected responses are queued when a grant is
// predicted and popped by a negedge monitor that also checks busy, op_count
// and that idle channels hold their last result. A second instance with
// CNT_W=4 covers counter saturation. Build with +define+RS_SHARE_SUB_EN to
// include the subtract scenario.
// -----------------------------------------------------------------------------
module tb_rs_share_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
`ifdef RS_SHARE_SUB_EN
    logic        req0_sub = 1'b0, req1_sub = 1'b0;
`endif
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid, rsp0_carry, rsp1_carry;
    logic [7:0]  rsp0_sum, rsp1_sum;
    logic        busy;
    logic [15:0] op_count;

    logic        sm_req0_valid = 1'b0;
    logic [7:0]  sm_req0_a = '0;
    logic        sm_req0_ready, sm_req1_ready;
    logic        sm_rsp0_valid, sm_rsp1_valid, sm_rsp0_carry, sm_rsp1_carry;
    logic [7:0]  sm_rsp0_sum, sm_rsp1_sum;
    logic        sm_busy;
    logic [3:0]  sm_op_count;

    rs_share_sched #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
`ifdef RS_SHARE_SUB_EN
        .req0_sub   (req0_sub),
`endif
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef RS_SHARE_SUB_EN
        .req1_sub   (req1_sub),
`endif
        .rsp0_valid (rsp0_valid),
        .rsp0_sum   (rsp0_sum),
        .rsp0_carry (rsp0_carry),
        .rsp1_valid (rsp1_valid),
        .rsp1_sum   (rsp1_sum),
        .rsp1_carry (rsp1_carry),
        .busy       (busy),
        .op_count   (op_count)
    );

    rs_share_sched #(.WIDTH(8), .CNT_W(4)) dut_sm (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (sm_req0_valid),
        .req0_ready (sm_req0_ready),
        .req0_a     (sm_req0_a),
        .req0_b     (8'd1),
`ifdef RS_SHARE_SUB_EN
        .req0_sub   (1'b0),
`endif
        .req1_valid (1'b0),
        .req1_ready (sm_req1_ready),
        .req1_a     (8'd0),
        .req1_b     (8'd0),
`ifdef RS_SHARE_SUB_EN
        .req1_sub   (1'b0),
`endif
        .rsp0_valid (sm_rsp0_valid),
        .rsp0_sum   (sm_rsp0_sum),
        .rsp0_carry (sm_rsp0_carry),
        .rsp1_valid (sm_rsp1_valid),
        .rsp1_sum   (sm_rsp1_sum),
        .rsp1_carry (sm_rsp1_carry),
        .busy       (sm_busy),
        .op_count   (sm_op_count)
    );

    typedef struct {
        int         due;
        logic       chan;
        logic [7:0] sum;
        logic       carry;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    logic        m_ptr    = 1'b0;
    logic [7:0]  m_sum0 = '0, m_sum1 = '0;
    logic        m_carry0 = 1'b0, m_carry1 = 1'b0;
    logic [15:0] m_cnt = '0;
    exp_t        mon_e;
    bit          mon_hit;
    bit          mon_busy;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] model_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
        logic [7:0] d;
        if (sub) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Monitor: runs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_hit  = (sb.size() > 0) && (sb[0].due == cyc);
            mon_busy = 1'b0;
            foreach (sb[i]) if (sb[i].due == cyc || sb[i].due == cyc + 1) mon_busy = 1'b1;
            n_checks++;
            if (busy !== mon_busy) begin
                n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, mon_busy);
            end
            n_checks++;
            if (op_count !== m_cnt) begin
                n_fail++; $display("FAIL op_count cyc=%0d got=%0d exp=%0d", cyc, op_count, m_cnt);
            end
            if (mon_hit) begin
                mon_e = sb.pop_front();
                if (mon_e.chan) begin m_sum1 = mon_e.sum; m_carry1 = mon_e.carry; end
                else begin m_sum0 = mon_e.sum; m_carry0 = mon_e.carry; end
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            n_checks++;
            if (rsp0_valid !== (mon_hit && !mon_e.chan) || rsp1_valid !== (mon_hit && mon_e.chan)) begin
                n_fail++;
                $display("FAIL rsp_valid cyc=%0d got=%b%b exp=%b%b", cyc, rsp1_valid, rsp0_valid,
                         mon_hit && mon_e.chan, mon_hit && !mon_e.chan);
            end
            n_checks++;
            if ({rsp0_carry, rsp0_sum} !== {m_carry0, m_sum0}) begin
                n_fail++; $display("FAIL rsp0_result cyc=%0d got=%h exp=%h", cyc, {rsp0_carry, rsp0_sum}, {m_carry0, m_sum0});
            end
            n_checks++;
            if ({rsp1_carry, rsp1_sum} !== {m_carry1, m_sum1}) begin
                n_fail++; $display("FAIL rsp1_result cyc=%0d got=%h exp=%h", cyc, {rsp1_carry, rsp1_sum}, {m_carry1, m_sum1});
            end
        end
    end

    // Drive one cycle of requests (called at a falling edge), check the
    // predicted grant, queue the expected response, move to the next falling edge.
    task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic s0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic s1);
        logic       g0, g1, s0e, s1e;
        logic [8:0] r;
        exp_t       e;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
`ifdef RS_SHARE_SUB_EN
        req0_sub = s0; req1_sub = s1;
        s0e = s0; s1e = s1;
`else
        s0e = 1'b0; s1e = 1'b0;
`endif
        #1;
        g0 = v0 && (!v1 || m_ptr == 1'b0);
        g1 = v1 && (!v0 || m_ptr == 1'b1);
        n_checks++;
        if (req0_ready !== g0 || req1_ready !== g1) begin
            n_fail++; $display("FAIL grant cyc=%0d got=%b%b exp=%b%b", cyc, req1_ready, req0_ready, g1, g0);
        end
        if (g0 || g1) begin
            r       = g1 ? model_op(a1, b1, s1e) : model_op(a0, b0, s0e);
            e.due   = cyc + 2;
            e.chan  = g1;
            e.sum   = r[7:0];
            e.carry = r[8];
            sb.push_back(e);
            m_ptr   = g0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic apply_reset(input int hold);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        sb.delete();
        m_ptr = 1'b0; m_cnt = '0;
        m_sum0 = '0; m_sum1 = '0; m_carry0 = 1'b0; m_carry1 = 1'b0;
        repeat (hold) @(negedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=00000", {rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready});
        end
        n_checks++;
        if ({rsp0_carry, rsp0_sum, rsp1_carry, rsp1_sum} !== 18'd0 || op_count !== 16'd0 || sm_op_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_values got=%h/%h/%0d/%0d exp=0", {rsp0_carry, rsp0_sum}, {rsp1_carry, rsp1_sum}, op_count, sm_op_count);
        end
        apply_reset(1);
    endtask

    task automatic test_single();
        drive(1, 8'd12, 8'd30, 0, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_arbitration();
        apply_reset(2);
        drive(1, 8'd1, 8'd2, 0, 1, 8'd10, 8'd20, 0);
        drive(1, 8'd3, 8'd4, 0, 1, 8'd30, 8'd40, 0);
        drive(1, 8'd5, 8'd6, 0, 1, 8'd50, 8'd60, 0);
        drive(1, 8'd7, 8'd8, 0, 1, 8'd70, 8'd80, 0);
        drain();
    endtask

    task automatic test_overflow();
        drive(0, 0, 0, 0, 1, 8'hFF, 8'h01, 0);
        drive(1, 8'h80, 8'h80, 0, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        drain();
    endtask

    task automatic test_reset_mid_op();
        drive(1, 8'd9, 8'd9, 0, 0, 0, 0, 0);
        apply_reset(1);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (busy !== 1'b0 || op_count !== 16'd0 || rsp0_sum !== 8'd0) begin
            n_fail++; $display("FAIL reset_mid_op got busy=%b cnt=%0d sum=%0d exp=0/0/0", busy, op_count, rsp0_sum);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        sm_req0_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sm_req0_a = 8'(i);
            #1;
            n_checks++;
            if (sm_req0_ready !== 1'b1) begin
                n_fail++; $display("FAIL sat_ready i=%0d got=%b exp=1", i, sm_req0_ready);
            end
            @(negedge clk);
            exp_cnt = (i > 1) ? i - 1 : 0;
            if (exp_cnt > 15) exp_cnt = 15;
            n_checks++;
            if (sm_busy !== 1'b1 || sm_op_count !== 4'(exp_cnt)) begin
                n_fail++; $display("FAIL sat_run i=%0d got busy=%b cnt=%0d exp=1/%0d", i, sm_busy, sm_op_count, exp_cnt);
            end
        end
        sm_req0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sm_busy !== 1'b1 || sm_op_count !== 4'd15) begin
            n_fail++; $display("FAIL sat_tail got busy=%b cnt=%0d exp=1/15", sm_busy, sm_op_count);
        end
        @(negedge clk);
        n_checks++;
        if (sm_busy !== 1'b0 || sm_op_count !== 4'd15) begin
            n_fail++; $display("FAIL sat_final got busy=%b cnt=%0d exp=0/15", sm_busy, sm_op_count);
        end
    endtask

`ifdef RS_SHARE_SUB_EN
    task automatic test_subtract();
        drive(1, 8'd5, 8'd7, 1, 0, 0, 0, 0);
        drive(1, 8'd7, 8'd5, 1, 0, 0, 0, 0);
        drive(1, 8'd7, 8'd7, 1, 1, 8'd0, 8'd1, 1);
        drive(0, 0, 0, 0, 1, 8'd3, 8'd4, 0);
        drain();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_overflow();
        test_back_to_back();
        test_reset_mid_op();
        test_saturation();
`ifdef RS_SHARE_SUB_EN
        test_subtract();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
